// File: rtl/hc_pkg.sv
// Shared types, register map and decode helpers for the HardCloud MMIO CSR block.
package hc_pkg;

  localparam int HC_NUM_BUFFERS = 2;

  typedef logic [17:0] t_hc_byte_addr;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [1:0] {
    S_CSR_RESET = 2'd0,
    S_CSR_IDLE  = 2'd1,
    S_CSR_RUN   = 2'd2,
    S_CSR_DONE  = 2'd3
  } t_csr_state;

  localparam logic [31:0] HC_CTL_ASSERT_RST   = 32'd0;
  localparam logic [31:0] HC_CTL_DEASSERT_RST = 32'd1;
  localparam logic [31:0] HC_CTL_START        = 32'd3;
  localparam logic [31:0] HC_CTL_STOP         = 32'd7;

  // AFU type 1 in [63:60], end-of-list in bit 40
  localparam logic [63:0] HC_AFU_DFH = 64'h1000_0100_0000_0000;

  localparam t_hc_byte_addr HC_DFH_OFF      = 18'h000;
  localparam t_hc_byte_addr HC_AFU_ID_L_OFF = 18'h008;
  localparam t_hc_byte_addr HC_AFU_ID_H_OFF = 18'h010;
  localparam t_hc_byte_addr HC_DSM_OFF      = 18'h110;
  localparam t_hc_byte_addr HC_CTL_OFF      = 18'h118;
  localparam t_hc_byte_addr HC_BUF_BASE     = 18'h120;
  localparam t_hc_byte_addr HC_MMIO_LIMIT   = 18'h400;

  function automatic logic [13:0] hc_buffer_index(input t_hc_byte_addr b);
    t_hc_byte_addr off;
    off = b - HC_BUF_BASE;
    return 14'(off >> 4);
  endfunction

  function automatic logic hc_buf_addr_sel(input t_hc_byte_addr b, input int i);
    return (b >= HC_BUF_BASE) && (b < HC_MMIO_LIMIT) && (b[3:0] == 4'h0) &&
           (hc_buffer_index(b) == 14'(i));
  endfunction

  function automatic logic hc_buf_size_sel(input t_hc_byte_addr b, input int i);
    return (b >= HC_BUF_BASE) && (b < HC_MMIO_LIMIT) && (b[3:0] == 4'h8) &&
           (hc_buffer_index(b) == 14'(i));
  endfunction

endpackage

// File: rtl/hc_csr_ctrl.sv
// Run-control FSM: turns host control-word writes and hc_done into user reset/start/running.
module hc_csr_ctrl
  import hc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld_i,
  input  logic [31:0] cmd_i,
  input  logic        done_i,
  output t_csr_state  state_o,
  output logic        start_o,
  output logic        running_o,
  output logic        user_rst_n_o
);

  t_csr_state state_q, state_d;
  logic       start_q, start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CSR_RESET;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // ASSERT_RST wins over everything, including hc_done
    if (cmd_vld_i && cmd_i == HC_CTL_ASSERT_RST) begin
      state_d = S_CSR_RESET;
    end else begin
      case (state_q)
        S_CSR_RESET: if (cmd_vld_i && cmd_i == HC_CTL_DEASSERT_RST) state_d = S_CSR_IDLE;
        S_CSR_IDLE:  if (cmd_vld_i && cmd_i == HC_CTL_START)        state_d = S_CSR_RUN;
        S_CSR_RUN:   if ((cmd_vld_i && cmd_i == HC_CTL_STOP) || done_i) state_d = S_CSR_DONE;
        S_CSR_DONE:  if (cmd_vld_i && cmd_i == HC_CTL_START)        state_d = S_CSR_RUN;
        default:     state_d = S_CSR_RESET;
      endcase
    end
    start_d = (state_d == S_CSR_RUN) && (state_q != S_CSR_RUN);
  end

  always_comb begin
    state_o      = state_q;
    start_o      = start_q;
    running_o    = (state_q == S_CSR_RUN);
    user_rst_n_o = (state_q != S_CSR_RESET);
  end

endmodule

// File: rtl/hc_csr.sv
// HardCloud MMIO CSR file: write decode, config registers, one-cycle read response.
module hc_csr
  import hc_pkg::*;
#(
  parameter int          HC_BUFFER_SIZE = HC_NUM_BUFFERS,
  parameter logic [63:0] AFU_ID_L       = 64'h0,
  parameter logic [63:0] AFU_ID_H       = 64'h0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  t_if_ccip_c0_Rx                       rx_mmio_channel,
  output t_if_ccip_c2_Tx                       tx_mmio_channel,
  output logic [63:0]                          hc_dsm_base,
  output t_hc_buffer [HC_BUFFER_SIZE-1:0]      hc_buffer,
  output logic                                 hc_user_rst_n,
  output logic                                 hc_start,
  output logic                                 hc_running,
  input  logic                                 hc_done
);

  t_hc_byte_addr                     req_byte;
  logic                              in_map, wr_en, cfg_wr_en;
  logic [63:0]                       wr_data;
  logic [63:0]                       dsm_base_q;
  t_hc_buffer [HC_BUFFER_SIZE-1:0]   buf_q;
  t_if_ccip_c2_Tx                    tx_q, tx_d;
  t_csr_state                        state;
  logic                              unused_rx;

  assign req_byte  = {rx_mmio_channel.hdr.address, 2'b00};
  assign in_map    = (req_byte < HC_MMIO_LIMIT);
  assign wr_data   = rx_mmio_channel.data[63:0];
  assign wr_en     = rx_mmio_channel.mmioWrValid && in_map;
  // Descriptors are frozen while user logic may be consuming them
  assign cfg_wr_en = wr_en && (state != S_CSR_RUN);
  assign unused_rx = ^{rx_mmio_channel.data[511:64], rx_mmio_channel.hdr.length,
                       rx_mmio_channel.hdr.rsvd, rx_mmio_channel.rspValid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsm_base_q <= '0;
      buf_q      <= '0;
    end else if (cfg_wr_en) begin
      if (req_byte == HC_DSM_OFF) dsm_base_q <= wr_data;
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
        if (hc_buf_addr_sel(req_byte, i)) buf_q[i].address <= wr_data;
        if (hc_buf_size_sel(req_byte, i)) buf_q[i].size    <= wr_data[31:0];
      end
    end
  end

  hc_csr_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_vld_i    (wr_en && req_byte == HC_CTL_OFF),
    .cmd_i        (wr_data[31:0]),
    .done_i       (hc_done),
    .state_o      (state),
    .start_o      (hc_start),
    .running_o    (hc_running),
    .user_rst_n_o (hc_user_rst_n)
  );

  always_comb begin
    tx_d             = '0;
    tx_d.mmioRdValid = rx_mmio_channel.mmioRdValid;
    tx_d.hdr.tid     = rx_mmio_channel.hdr.tid;
    if (rx_mmio_channel.mmioRdValid && in_map) begin
      case (req_byte)
        HC_DFH_OFF:      tx_d.data = HC_AFU_DFH;
        HC_AFU_ID_L_OFF: tx_d.data = AFU_ID_L;
        HC_AFU_ID_H_OFF: tx_d.data = AFU_ID_H;
        HC_DSM_OFF:      tx_d.data = dsm_base_q;
        HC_CTL_OFF:      tx_d.data = {60'h0, hc_done, hc_running, state};
        default: begin
          for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
            if (hc_buf_addr_sel(req_byte, i)) tx_d.data = buf_q[i].address;
            if (hc_buf_size_sel(req_byte, i)) tx_d.data = {32'h0, buf_q[i].size};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= '0;
    else        tx_q <= tx_d;
  end

  assign tx_mmio_channel = tx_q;
  assign hc_dsm_base     = dsm_base_q;
  assign hc_buffer       = buf_q;

endmodule

// File: tb/tb_hc_csr.sv
// Directed bench for hc_csr: register map table plus run-control corner sequences.
module tb_hc_csr;
  import hc_pkg::*;

  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  t_if_ccip_c0_Rx rx;
  t_if_ccip_c2_Tx tx;
  logic [63:0]    dsm;
  t_hc_buffer [1:0] bufs;
  logic           user_rst_n, start, running, done;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hc_csr #(.HC_BUFFER_SIZE(2), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_mmio_channel (rx),
    .tx_mmio_channel (tx),
    .hc_dsm_base     (dsm),
    .hc_buffer       (bufs),
    .hc_user_rst_n   (user_rst_n),
    .hc_start        (start),
    .hc_running      (running),
    .hc_done         (done)
  );

  typedef struct {
    bit          wr;
    logic [17:0] a;
    logic [63:0] d;
    logic [8:0]  tid;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mmio_wr(input logic [17:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    rx = '0;
    rx.hdr.address = a[17:2];
    rx.data[63:0]  = d;
    rx.mmioWrValid = 1'b1;
    @(posedge clk); #1;
    rx = '0;
  endtask

  task automatic mmio_rd(input logic [17:0] a, input logic [8:0] tid,
                         input logic [63:0] exp, input string nm);
    @(posedge clk); #1;
    rx = '0;
    rx.hdr.address = a[17:2];
    rx.hdr.tid     = tid;
    rx.mmioRdValid = 1'b1;
    @(posedge clk); #1;
    rx = '0;
    chk({nm, " vld"}, 64'(tx.mmioRdValid), 64'h1);
    chk({nm, " tid"}, 64'(tx.hdr.tid), 64'(tid));
    chk({nm, " data"}, tx.data, exp);
  endtask

  initial begin
    rx   = '0;
    done = 1'b0;

    vecs.push_back('{1'b1, 18'h110, 64'hABCD_0000_1234_0000, 9'd0, 64'h0, "wr dsm"});
    vecs.push_back('{1'b1, 18'h120, 64'h1000_0000, 9'd0, 64'h0, "wr buf0 addr"});
    vecs.push_back('{1'b1, 18'h128, 64'hFFFF_FFFF_0000_0040, 9'd0, 64'h0, "wr buf0 size"});
    vecs.push_back('{1'b1, 18'h130, 64'h2000_0000, 9'd0, 64'h0, "wr buf1 addr"});
    vecs.push_back('{1'b1, 18'h140, 64'hDEAD, 9'd0, 64'h0, "wr past bufs"});
    vecs.push_back('{1'b0, 18'h110, 64'h0, 9'd17, 64'hABCD_0000_1234_0000, "rd dsm"});
    vecs.push_back('{1'b0, 18'h120, 64'h0, 9'd18, 64'h1000_0000, "rd buf0 addr"});
    vecs.push_back('{1'b0, 18'h128, 64'h0, 9'd19, 64'h40, "rd buf0 size"});
    vecs.push_back('{1'b0, 18'h130, 64'h0, 9'd20, 64'h2000_0000, "rd buf1 addr"});
    vecs.push_back('{1'b0, 18'h138, 64'h0, 9'd21, 64'h0, "rd buf1 size"});
    vecs.push_back('{1'b0, 18'h140, 64'h0, 9'd22, 64'h0, "rd past bufs"});
    vecs.push_back('{1'b0, 18'h010, 64'h0, 9'd23, ID_H, "rd afu id h"});
    vecs.push_back('{1'b0, 18'h018, 64'h0, 9'd24, 64'h0, "rd rsvd 18"});
    vecs.push_back('{1'b0, 18'h118, 64'h0, 9'd25, 64'h1, "rd status idle"});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst user_rst_n", 64'(user_rst_n), 64'h0);
    chk("rst tx vld", 64'(tx.mmioRdValid), 64'h0);
    chk("rst dsm", dsm, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle no tx vld", 64'(tx.mmioRdValid), 64'h0);
    chk("rst running", 64'(running), 64'h0);
    chk("rst start", 64'(start), 64'h0);
    mmio_rd(18'h118, 9'd5, 64'h0, "rd status reset");

    // RESET -> IDLE, undefined code ignored
    mmio_wr(18'h118, 64'h1);
    chk("idle user_rst_n", 64'(user_rst_n), 64'h1);
    mmio_wr(18'h118, 64'h5);
    mmio_rd(18'h118, 9'd6, 64'h1, "rd status after undef");

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        mmio_wr(vecs[i].a, vecs[i].d);
        chk({vecs[i].nm, " no tx"}, 64'(tx.mmioRdValid), 64'h0);
      end else begin
        mmio_rd(vecs[i].a, vecs[i].tid, vecs[i].exp, vecs[i].nm);
      end
    end
    chk("out buf0 addr", bufs[0].address, 64'h1000_0000);
    chk("out buf0 size", 64'(bufs[0].size), 64'h40);
    chk("out buf1 addr", bufs[1].address, 64'h2000_0000);
    chk("out dsm", dsm, 64'hABCD_0000_1234_0000);

    // IDLE -> RUN: one-cycle start pulse
    mmio_wr(18'h118, 64'h3);
    chk("start pulse", 64'(start), 64'h1);
    chk("running", 64'(running), 64'h1);
    @(posedge clk); #1;
    chk("start pulse end", 64'(start), 64'h0);

    // Config is locked in RUN
    mmio_wr(18'h128, 64'h80);
    mmio_wr(18'h110, 64'h5555);
    mmio_rd(18'h128, 9'd30, 64'h40, "rd locked size");
    chk("locked dsm", dsm, 64'hABCD_0000_1234_0000);
    mmio_rd(18'h118, 9'd31, 64'h6, "rd status run");

    // hc_done pulse -> DONE
    @(posedge clk); #1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("done running", 64'(running), 64'h0);
    mmio_rd(18'h118, 9'd32, 64'h3, "rd status done");

    // DONE -> RUN again, fresh start pulse
    mmio_wr(18'h118, 64'h3);
    chk("rerun start", 64'(start), 64'h1);
    chk("rerun running", 64'(running), 64'h1);

    // STOP and hc_done in the same cycle
    @(posedge clk); #1;
    rx = '0;
    rx.hdr.address = 16'(18'h118 >> 2);
    rx.data[63:0]  = 64'h7;
    rx.mmioWrValid = 1'b1;
    done = 1'b1;
    @(posedge clk); #1;
    rx = '0;
    done = 1'b0;
    chk("stop+done running", 64'(running), 64'h0);
    chk("stop+done start", 64'(start), 64'h0);
    @(posedge clk); #1;
    chk("stop+done start later", 64'(start), 64'h0);
    mmio_rd(18'h118, 9'd33, 64'h3, "rd status stop+done");

    // ASSERT_RST
    mmio_wr(18'h118, 64'h0);
    chk("assert rst user_rst_n", 64'(user_rst_n), 64'h0);
    mmio_rd(18'h118, 9'd34, 64'h0, "rd status rst");

    // Back-to-back reads
    for (int i = 0; i <= 4; i++) begin
      logic [17:0] ba [4];
      logic [63:0] be [4];
      ba = '{18'h000, 18'h008, 18'h3F8, 18'h400};
      be = '{HC_AFU_DFH, ID_L, 64'h0, 64'h0};
      @(posedge clk); #1;
      if (i > 0) begin
        chk($sformatf("b2b%0d vld", i - 1), 64'(tx.mmioRdValid), 64'h1);
        chk($sformatf("b2b%0d tid", i - 1), 64'(tx.hdr.tid), 64'(40 + i - 1));
        chk($sformatf("b2b%0d data", i - 1), tx.data, be[i-1]);
      end
      rx = '0;
      if (i < 4) begin
        rx.hdr.address = ba[i][17:2];
        rx.hdr.tid     = 9'(40 + i);
        rx.mmioRdValid = 1'b1;
      end
    end

    // Async reset mid-run drops an in-flight read
    mmio_wr(18'h118, 64'h1);
    mmio_wr(18'h118, 64'h3);
    chk("pre-rst running", 64'(running), 64'h1);
    @(posedge clk); #1;
    rx = '0;
    rx.hdr.address = 16'(18'h110 >> 2);
    rx.hdr.tid     = 9'd50;
    rx.mmioRdValid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst running", 64'(running), 64'h0);
    @(posedge clk); #1;
    rx = '0;
    chk("async rst tx vld", 64'(tx.mmioRdValid), 64'h0);
    chk("async rst user_rst_n", 64'(user_rst_n), 64'h0);
    chk("async rst buf0", bufs[0].address, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
